// File: rtl/dmem_lsu.sv
// Single-port data memory with load/store unit: byte/half/word access, sign/zero extension,
// range/size fault reporting and a power-up CLEAR sweep. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_lsu #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_idx_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        req_ready   = 1'b0;
        case (state)
            CLEAR: begin
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) state_nxt = RUN;
            end
            RUN:     req_ready = 1'b1;
            default: state_nxt = CLEAR;
        endcase
    end

    logic          accept;
    logic [31:0]   offset;
    logic          in_range;
    logic          misalign;
    logic          req_err;
    logic [1:0]    lane;
    logic [AW-1:0] word_idx;

    assign accept   = req_valid && req_ready;
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign word_idx = offset[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = !in_range || (req_size == SZ_BAD) || misalign;

    // Misaligned halves/words are forced onto their natural boundary when not trapped.
    always_comb begin
        case (req_size)
            SZ_HALF: lane = {req_addr[1], 1'b0};
            SZ_WORD: lane = 2'b00;
            default: lane = req_addr[1:0];
        endcase
    end

    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] wdata_lane;

    assign wr_en = accept && req_we && !req_err;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                be         = 4'b0001 << lane;
                wdata_lane = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{req_wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;

    // NOTE: the array and its read register have no reset; zeroing is done by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
        if (accept && !req_we) rd_word <= mem[word_idx];
    end

    logic       r_load;
    logic [1:0] r_size;
    logic [1:0] r_lane;
    logic       r_unsigned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            r_load     <= 1'b0;
            r_size     <= SZ_BYTE;
            r_lane     <= 2'b00;
            r_unsigned <= 1'b0;
        end else begin
            resp_valid <= accept;
            resp_err   <= accept && req_err;
            r_load     <= accept && !req_we && !req_err;
            r_size     <= req_size;
            r_lane     <= lane;
            r_unsigned <= req_unsigned;
        end
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rd_word[8*r_lane +: 8];
    assign rd_half = r_lane[1] ? rd_word[31:16] : rd_word[15:0];

    // Extension happens after the registered read so the array maps onto block RAM.
    always_comb begin
        resp_rdata = '0;
        if (r_load) begin
            case (r_size)
                SZ_BYTE: resp_rdata = r_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                SZ_HALF: resp_rdata = r_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                SZ_WORD: resp_rdata = rd_word;
                default: resp_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table driven back-to-back through a scoreboard,
// plus hand sequences for power-up CLEAR and reset with a response in flight.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_lsu #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: each response must match the head entry on the cycle right after its accept.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious resp_valid", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("v%0d latency", e.id), 32'(cyc), 32'(e.acc));
                    check($sformatf("v%0d rdata", e.id), resp_rdata, e.rdata);
                    check($sformatf("v%0d err", e.id), 32'(resp_err), 32'(e.err));
                end
            end else begin
                check("idle rdata/err", {resp_rdata[30:0], resp_err}, 32'd0);
                if (sb.size() > 0 && sb[0].acc < cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("v%0d missing response", e.id), 32'(resp_valid), 32'd1);
                end
            end
        end
    end

    task automatic add(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                       logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
        tbl.push_back('{we, size, uns, addr, wdata, exp_rdata, exp_err});
    endtask

    task automatic drive(logic we, logic [1:0] size, logic uns, logic [31:0] addr, logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic run_table();
        int n;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (!req_ready) check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
            drive(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
            sb.push_back('{tbl[i].exp_rdata, tbl[i].exp_err, cyc + 1, i});
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        sb.delete();
        tbl.delete();
    endtask

    // Counts edges from reset release until req_ready, with a load held on req_valid throughout.
    task automatic wait_ready(string name);
        int   n = 0;
        logic saw = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        while (!req_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_valid) saw = 1'b1;
        end
        req_valid = 1'b0;
        check({name, " clear cycles"}, 32'(n), 32'd256);
        check({name, " no resp in clear"}, 32'(saw), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        reset_n = 1'b1;
        wait_ready("powerup");

        //  we    size   uns   addr          wdata         exp_rdata     exp_err
        add(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,        32'h0000_0000, 1'b0);
        add(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        32'h0000_00BE, 1'b0);
        add(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        32'hFFFF_FFEF, 1'b0);
        add(1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_0080, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h8000_0000, 1'b0);
        add(1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0,        32'hFFFF_FF80, 1'b0);
        add(1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,        32'h0000_0080, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add(1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        32'h0000_0000, 1'b1);
`else
        add(1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'h0,        32'h0000_BEEF, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        32'hDEADBEEF, 1'b0);
`endif
        add(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h12345678, 32'h0000_0000, 1'b1);
        add(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 1'b1);
        add(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1);
        add(1'b1, 2'b01, 1'b0, 32'h0000_0032, 32'h1234A5A5, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        32'hA5A5_0000, 1'b0);
        add(1'b0, 2'b01, 1'b0, 32'h0000_0032, 32'h0,        32'hFFFF_A5A5, 1'b0);
        add(1'b0, 2'b01, 1'b1, 32'h0000_0030, 32'h0,        32'h0000_0000, 1'b0);
        add(1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'hFFFF_FF7F, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        32'hA5A5_7F00, 1'b0);
        add(1'b0, 2'b00, 1'b0, 32'h0000_0031, 32'h0,        32'h0000_007F, 1'b0);
        add(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFEF00D, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,        32'hCAFEF00D, 1'b0);
        add(1'b0, 2'b01, 1'b0, 32'h0000_03FE, 32'h0,        32'hFFFF_CAFE, 1'b0);
        mon_en = 1'b1;
        run_table();
        mon_en = 1'b0;

        // Store then load back-to-back, then reset while the load response is on the outputs.
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1111_1111);
        @(posedge clk);
        #1;
        check("pre-reset store resp_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        @(posedge clk);
        #1;
        check("pre-reset load resp_valid", 32'(resp_valid), 32'd1);
        check("pre-reset load rdata", resp_rdata, 32'h1111_1111);
        #1;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        #1;
        check("async reset resp_valid", 32'(resp_valid), 32'd0);
        check("async reset resp_rdata", resp_rdata, 32'd0);
        check("async reset req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("held reset resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready("rerun");

        add(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0000, 1'b0);
        mon_en = 1'b1;
        run_table();
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
